// File: rtl/pr2_pkg.sv
// Shared definitions for the R-type execution unit: instruction layout, opcode/funct codes, FSM states.
package pr2_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rinstr_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

endpackage

// File: rtl/rtype_regfile.sv
// 32x32 register file: two read ports, one write port, one debug read port; R0 reads zero.
// Reads are combinational; a write is visible on the cycle after it.
module rtype_regfile
  import pr2_pkg::*;
#(
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [XLEN-1:0]   rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [XLEN-1:0]   rdata_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  logic [NUM_REGS-1:0][XLEN-1:0] regs_q;
  logic [NUM_REGS-1:0][XLEN-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Without clear-on-reset the contents simply survive the reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (CLR_ON_RST) begin
        regs_q <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a  = (raddr_a  == '0) ? '0 : regs_q[raddr_a];
  assign rdata_b  = (raddr_b  == '0) ? '0 : regs_q[raddr_b];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/rtype_exec_unit.sv
// MIPS R-type execution unit: IDLE/DECODE/EXECUTE/WRITEBACK, accept-to-result_valid 3 cycles, one command per 4.
// instr_ready only in IDLE with no preload pending; a preload in IDLE wins over a command.
module rtype_exec_unit
  import pr2_pkg::*;
#(
  parameter bit REGFILE_CLR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        ld_en,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] result,
  output logic        result_valid,
  output logic [4:0]  result_rd,
  output logic        ovf,
  output logic        illegal
);

  state_t        state_q, state_d;
  rinstr_t       instr_q, instr_d;
  logic [31:0]   rs_val_q, rs_val_d;
  logic [31:0]   rt_val_q, rt_val_d;
  logic [31:0]   result_q, result_d;
  logic [4:0]    result_rd_q, result_rd_d;
  logic          ovf_q, ovf_d;
  logic          illegal_q, illegal_d;

  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [31:0]   rf_rdata_a;
  logic [31:0]   rf_rdata_b;

  logic [31:0]   alu_sum;
  logic [31:0]   alu_diff;
  logic [31:0]   alu_res;
  logic          alu_ovf;
  logic          alu_illegal;

  rtype_regfile #(
    .CLR_ON_RST (REGFILE_CLR)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .raddr_a  (instr_q.rs),
    .rdata_a  (rf_rdata_a),
    .raddr_b  (instr_q.rt),
    .rdata_b  (rf_rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign alu_sum  = rs_val_q + rt_val_q;
  assign alu_diff = rs_val_q - rt_val_q;

  always_comb begin
    alu_res     = '0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    if (instr_q.op != OP_RTYPE) begin
      alu_illegal = 1'b1;
    end else begin
      case (instr_q.funct)
        FN_ADD: begin
          alu_res = alu_sum;
          alu_ovf = (rs_val_q[31] == rt_val_q[31]) && (alu_sum[31] != rs_val_q[31]);
        end
        FN_ADDU: alu_res = alu_sum;
        FN_SUB: begin
          alu_res = alu_diff;
          alu_ovf = (rs_val_q[31] != rt_val_q[31]) && (alu_diff[31] != rs_val_q[31]);
        end
        FN_SUBU: alu_res = alu_diff;
        FN_AND:  alu_res = rs_val_q & rt_val_q;
        FN_OR:   alu_res = rs_val_q | rt_val_q;
        FN_XOR:  alu_res = rs_val_q ^ rt_val_q;
        FN_NOR:  alu_res = ~(rs_val_q | rt_val_q);
        FN_SLT:  alu_res = {31'd0, $signed(rs_val_q) < $signed(rt_val_q)};
        FN_SLTU: alu_res = {31'd0, rs_val_q < rt_val_q};
        FN_SLL:  alu_res = rt_val_q << instr_q.shamt;
        FN_SRL:  alu_res = rt_val_q >> instr_q.shamt;
        FN_SRA:  alu_res = $signed(rt_val_q) >>> instr_q.shamt;
        default: alu_illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    rs_val_d    = rs_val_q;
    rt_val_d    = rt_val_q;
    result_d    = result_q;
    result_rd_d = result_rd_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = ld_addr;
    rf_wdata    = ld_data;
    case (state_q)
      IDLE: begin
        instr_ready = !ld_en;
        if (ld_en) begin
          rf_we = 1'b1;
        end else if (instr_valid) begin
          instr_d = rinstr_t'(instr);
          state_d = DECODE;
        end
      end
      DECODE: begin
        rs_val_d = rf_rdata_a;
        rt_val_d = rf_rdata_b;
        state_d  = EXECUTE;
      end
      EXECUTE: begin
        result_d    = alu_res;
        result_rd_d = instr_q.rd;
        ovf_d       = alu_ovf;
        illegal_d   = alu_illegal;
        state_d     = WRITEBACK;
      end
      WRITEBACK: begin
        // The write lands on the edge back to IDLE, so the next DECODE sees it.
        rf_we    = !illegal_q;
        rf_waddr = result_rd_q;
        rf_wdata = result_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      result_rd_q <= '0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_rd_q <= result_rd_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
    end
  end

  always_ff @(posedge clk) begin
    instr_q  <= instr_d;
    rs_val_q <= rs_val_d;
    rt_val_q <= rt_val_d;
  end

  assign result       = result_q;
  assign result_rd    = result_rd_q;
  assign ovf          = ovf_q;
  assign illegal      = illegal_q;
  assign result_valid = (state_q == WRITEBACK);

endmodule

// File: tb/tb_rtype_exec_unit.sv
// Directed self-checking bench for rtype_exec_unit; drives and samples on the falling clock edge.
module tb_rtype_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] result;
  logic        result_valid;
  logic [4:0]  result_rd;
  logic        ovf;
  logic        illegal;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] exp_regs [32];

  rtype_exec_unit #(.REGFILE_CLR(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .result       (result),
    .result_valid (result_valid),
    .result_rd    (result_rd),
    .ovf          (ovf),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [31:0] rword(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    if (a != 5'd0) exp_regs[a] = d;
  endtask

  // Returns accept-to-result_valid latency in cycles, or -1 on timeout.
  task automatic issue(input logic [31:0] w, output int lat);
    int n;
    @(negedge clk);
    instr_valid = 1'b1; instr = w;
    n = 0;
    while (!instr_ready && n < 10) begin @(negedge clk); n++; end
    if (!instr_ready) begin
      instr_valid = 1'b0; lat = -1; return;
    end
    @(negedge clk);
    instr_valid = 1'b0; instr = 32'hFFFF_FFFF;
    lat = 1;
    while (!result_valid && lat < 10) begin @(negedge clk); lat++; end
    if (!result_valid) lat = -1;
  endtask

  task automatic test_reset;
    logic bad;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; ld_en = 1'b0;
    ld_addr = '0; ld_data = '0; dbg_addr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", instr_ready); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", result_valid); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_result: got %h want 0", result); end
    checks++; if (result_rd !== 5'd0) begin errors++; $display("FAIL rst_rd: got %0d want 0", result_rd); end
    checks++; if ({ovf, illegal} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b want 00", {ovf, illegal}); end
    bad = 1'b0;
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a); #1;
      if (dbg_data !== 32'd0) bad = 1'b1;
      exp_regs[a] = 32'd0;
    end
    checks++; if (bad) begin errors++; $display("FAIL rst_regs: got nonzero want all 0"); end
  endtask

  task automatic test_add;
    int lat;
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd3);
    issue(32'h0022_1820, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL add_latency: got %0d want 3", lat); end
    checks++; if (result !== 32'd8) begin errors++; $display("FAIL add_result: got %h want 8", result); end
    checks++; if (result_rd !== 5'd3) begin errors++; $display("FAIL add_rd: got %0d want 3", result_rd); end
    checks++; if ({ovf, illegal} !== 2'b00) begin errors++; $display("FAIL add_flags: got %b want 00", {ovf, illegal}); end
    exp_regs[3] = 32'd8;
    @(negedge clk);
    dbg_addr = 5'd3; #1;
    checks++; if (dbg_data !== 32'd8) begin errors++; $display("FAIL add_dbg_r3: got %h want 8", dbg_data); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL add_rvalid_pulse: got %b want 0", result_valid); end
    checks++; if (result !== 32'd8) begin errors++; $display("FAIL add_result_hold: got %h want 8", result); end
  endtask

  task automatic test_ovf;
    int lat;
    preload(5'd1, 32'h7FFF_FFFF);
    preload(5'd2, 32'd1);
    issue(rword(1, 2, 4, 0, 'h20), lat);
    checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL ovf_add_result: got %h want 80000000", result); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_add_flag: got %b want 1", ovf); end
    exp_regs[4] = 32'h8000_0000;
    @(negedge clk);
    dbg_addr = 5'd4; #1;
    checks++; if (dbg_data !== 32'h8000_0000) begin errors++; $display("FAIL ovf_dbg_r4: got %h want 80000000", dbg_data); end
    issue(rword(1, 2, 6, 0, 'h21), lat);
    checks++; if ({result, ovf} !== {32'h8000_0000, 1'b0}) begin errors++; $display("FAIL addu_noovf: got %h/%b want 80000000/0", result, ovf); end
    exp_regs[6] = 32'h8000_0000;
    issue(rword(4, 2, 7, 0, 'h22), lat);
    checks++; if ({result, ovf} !== {32'h7FFF_FFFF, 1'b1}) begin errors++; $display("FAIL sub_ovf: got %h/%b want 7fffffff/1", result, ovf); end
    exp_regs[7] = 32'h7FFF_FFFF;
  endtask

  task automatic test_slt;
    int lat;
    preload(5'd1, 32'hFFFF_FFFF);
    preload(5'd2, 32'd1);
    issue(rword(1, 2, 5, 0, 'h2A), lat);
    checks++; if (result !== 32'd1) begin errors++; $display("FAIL slt_result: got %h want 1", result); end
    issue(rword(1, 2, 5, 0, 'h2B), lat);
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL sltu_result: got %h want 0", result); end
    exp_regs[5] = 32'd0;
    @(negedge clk);
    dbg_addr = 5'd5; #1;
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL sltu_dbg_r5: got %h want 0", dbg_data); end
  endtask

  task automatic test_rd0_illegal;
    int lat;
    logic [31:0] w;
    issue(rword(1, 2, 0, 0, 'h25), lat);
    checks++; if ({result, result_rd} !== {32'hFFFF_FFFF, 5'd0}) begin errors++; $display("FAIL rd0_result: got %h/%0d want ffffffff/0", result, result_rd); end
    @(negedge clk);
    dbg_addr = 5'd0; #1;
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL rd0_r0: got %h want 0", dbg_data); end
    w = {6'h08, 5'd1, 5'd2, 5'd9, 5'd0, 6'h20};
    issue(w, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL illop_latency: got %0d want 3", lat); end
    checks++; if ({illegal, result, result_rd, ovf} !== {1'b1, 32'd0, 5'd9, 1'b0}) begin errors++; $display("FAIL illop_report: got %b/%h/%0d/%b want 1/0/9/0", illegal, result, result_rd, ovf); end
    issue(rword(1, 2, 9, 0, 'h3F), lat);
    checks++; if ({illegal, result} !== {1'b1, 32'd0}) begin errors++; $display("FAIL illfn_report: got %b/%h want 1/0", illegal, result); end
    @(negedge clk);
    dbg_addr = 5'd9; #1;
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL ill_r9: got %h want 0", dbg_data); end
    dbg_addr = 5'd2; #1;
    checks++; if (dbg_data !== 32'd1) begin errors++; $display("FAIL ill_r2: got %h want 1", dbg_data); end
  endtask

  task automatic test_ld_priority;
    int lat;
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 5'd10; ld_data = 32'hA5A5_A5A5;
    instr_valid = 1'b1; instr = rword(10, 0, 11, 0, 'h21);
    #1;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL ldprio_ready: got %b want 0", instr_ready); end
    @(negedge clk);
    ld_en = 1'b0;
    dbg_addr = 5'd10; #1;
    checks++; if (dbg_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL ldprio_r10: got %h want a5a5a5a5", dbg_data); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL ldprio_ready2: got %b want 1", instr_ready); end
    exp_regs[10] = 32'hA5A5_A5A5;
    @(negedge clk);                         // DECODE
    instr_valid = 1'b0;
    @(negedge clk);                         // EXECUTE
    ld_en = 1'b1; ld_addr = 5'd12; ld_data = 32'hDEAD_BEEF;
    @(negedge clk);                         // WRITEBACK
    ld_en = 1'b0;
    lat = result_valid ? 3 : -1;
    checks++; if (lat != 3) begin errors++; $display("FAIL ldprio_latency: got %0d want 3", lat); end
    checks++; if (result !== 32'hA5A5_A5A5) begin errors++; $display("FAIL ldprio_result: got %h want a5a5a5a5", result); end
    exp_regs[11] = 32'hA5A5_A5A5;
    @(negedge clk);
    dbg_addr = 5'd12; #1;
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL ld_exec_ignored: got %h want 0", dbg_data); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    instr_valid = 1'b1; instr = rword(1, 2, 14, 0, 'h20);
    @(negedge clk);                         // DECODE
    instr_valid = 1'b0;
    @(negedge clk);                         // EXECUTE
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({result_valid, result, result_rd, ovf, illegal} !== '0) begin errors++; $display("FAIL midrst_outputs: got %b/%h/%0d/%b/%b want all 0", result_valid, result, result_rd, ovf, illegal); end
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) exp_regs[a] = 32'd0;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", instr_ready); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid: got %b want 0", result_valid); end
    dbg_addr = 5'd14; #1;
    checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL midrst_r14: got %h want 0", dbg_data); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] words [11];
    logic [31:0] exps  [11];
    int lat;
    int prev;
    preload(5'd1, 32'h1234_5678);
    preload(5'd2, 32'h0000_000F);
    preload(5'd3, 32'h8000_0000);
    words[0]  = rword(1, 2, 4, 0, 'h20);   exps[0]  = 32'h1234_5687;
    words[1]  = rword(1, 2, 5, 0, 'h22);   exps[1]  = 32'h1234_5669;
    words[2]  = rword(1, 2, 6, 0, 'h24);   exps[2]  = 32'h0000_0008;
    words[3]  = rword(1, 2, 7, 0, 'h25);   exps[3]  = 32'h1234_567F;
    words[4]  = rword(1, 2, 8, 0, 'h26);   exps[4]  = 32'h1234_5677;
    words[5]  = rword(1, 2, 9, 0, 'h27);   exps[5]  = 32'hEDCB_A980;
    words[6]  = rword(0, 1, 10, 4, 'h00);  exps[6]  = 32'h2345_6780;
    words[7]  = rword(0, 3, 11, 4, 'h02);  exps[7]  = 32'h0800_0000;
    words[8]  = rword(0, 3, 12, 4, 'h03);  exps[8]  = 32'hF800_0000;
    words[9]  = rword(4, 5, 13, 0, 'h23);  exps[9]  = 32'h0000_001E;
    words[10] = rword(12, 13, 14, 0, 'h2A); exps[10] = 32'h0000_0001;
    prev = 0;
    for (int i = 0; i < 11; i++) begin
      issue(words[i], lat);
      checks++; if (lat != 3) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want 3", i, lat); end
      checks++; if ({result, result_rd, illegal} !== {exps[i], 5'(i + 4), 1'b0}) begin errors++; $display("FAIL b2b_result[%0d]: got %h/%0d/%b want %h/%0d/0", i, result, result_rd, illegal, exps[i], i + 4); end
      if (i > 0) begin
        checks++; if (cyc - prev != 4) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 4", i, cyc - prev); end
      end
      prev = cyc;
      exp_regs[i + 4] = exps[i];
    end
    @(negedge clk);
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a); #1;
      checks++; if (dbg_data !== exp_regs[a]) begin errors++; $display("FAIL dump_r%0d: got %h want %h", a, dbg_data, exp_regs[a]); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ovf();
    test_slt();
    test_rd0_illegal();
    test_ld_priority();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
